// File: rtl/gru_pkg.sv
// gru_pkg: shared GRU FSM state type, Q-format constants and saturation helper
package gru_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS = 8;
  localparam int ONE = 1 << FRAC_BITS;
  localparam int DW_MAX = (1 << (DATA_WIDTH - 1)) - 1;
  localparam int DW_MIN = -(1 << (DATA_WIDTH - 1));
  typedef enum logic [1:0] {COLLECT, DIFF, MULT, SUM} state_t;
  function automatic logic signed [DATA_WIDTH-1:0] sat_to_dw(input logic signed [31:0] x);
    return x > DW_MAX ? DATA_WIDTH'(DW_MAX) : x < DW_MIN ? DATA_WIDTH'(DW_MIN) : x[DATA_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/gru_fx_saturate.sv
// gru_fx_saturate: signed clamp IN_WIDTH -> DATA_WIDTH with clamped flag
//  i_x in IN_WIDTH, o_y out DATA_WIDTH, o_clamped out 1
module gru_fx_saturate #(
  parameter int IN_WIDTH = 34,
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0]   i_x,
  output logic signed [DATA_WIDTH-1:0] o_y,
  output logic                         o_clamped
);
  logic [IN_WIDTH-DATA_WIDTH:0] w_hi;
  // in range only when every bit above the result's sign bit matches it
  assign w_hi = i_x[IN_WIDTH-1:DATA_WIDTH-1];
  assign o_clamped = !(&w_hi || !(|w_hi));
  assign o_y = o_clamped ? {i_x[IN_WIDTH-1], {(DATA_WIDTH-1){~i_x[IN_WIDTH-1]}}} : i_x[DATA_WIDTH-1:0];
endmodule

// File: rtl/gru_hidden_state_update_element.sv
// gru_hidden_state_update_element: h = n + z*(h_prev - n) on one multiplier, 4-state FSM
//  clk, reset (sync, active-high); valid_z/z_t_n, valid_n/n_t_n: operand pulses in any order
//  h_t_prev_n: sampled when the pair is consumed; h_t_n/sat_flag: held result; valid_out: result pulse
//  busy: FSM not in COLLECT
module gru_hidden_state_update_element #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_z,
  input  logic signed [DATA_WIDTH-1:0] z_t_n,
  input  logic                         valid_n,
  input  logic signed [DATA_WIDTH-1:0] n_t_n,
  input  logic signed [DATA_WIDTH-1:0] h_t_prev_n,
  output logic signed [DATA_WIDTH-1:0] h_t_n,
  output logic                         valid_out,
  output logic                         sat_flag,
  output logic                         busy
);
  import gru_pkg::*;
  localparam int PW = 2 * DATA_WIDTH + 1;
  state_t r_state;
  logic signed [DATA_WIDTH-1:0] r_z_q, r_n_q, r_z_w, r_n_w, r_h_w, w_sat;
  logic r_z_got, r_n_got, w_go, w_clamped;
  logic signed [DATA_WIDTH:0] r_diff;
  logic signed [PW-1:0] r_prod, w_shift;
  logic signed [PW:0] w_sum;
  // a valid arriving this cycle can complete the pair
  assign w_go = r_state == COLLECT && (r_z_got || valid_z) && (r_n_got || valid_n);
  assign w_shift = r_prod >>> FRAC_BITS;
  assign w_sum = (PW+1)'(w_shift) + (PW+1)'(r_n_w);
  assign busy = r_state != COLLECT;
  gru_fx_saturate #(.IN_WIDTH(PW + 1), .DATA_WIDTH(DATA_WIDTH)) u_sat (
    .i_x(w_sum),
    .o_y(w_sat),
    .o_clamped(w_clamped)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= COLLECT;
      r_z_q <= '0;
      r_n_q <= '0;
      r_z_w <= '0;
      r_n_w <= '0;
      r_h_w <= '0;
      r_z_got <= 1'b0;
      r_n_got <= 1'b0;
      r_diff <= '0;
      r_prod <= '0;
      h_t_n <= '0;
      valid_out <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_z) r_z_q <= z_t_n;
      if (valid_n) r_n_q <= n_t_n;
      // a held operand is consumed first; a fresh pulse on that edge stays held for the next op
      if (w_go) begin
        r_z_w <= r_z_got ? r_z_q : z_t_n;
        r_n_w <= r_n_got ? r_n_q : n_t_n;
        r_h_w <= h_t_prev_n;
        r_z_got <= r_z_got && valid_z;
        r_n_got <= r_n_got && valid_n;
      end else begin
        r_z_got <= r_z_got || valid_z;
        r_n_got <= r_n_got || valid_n;
      end
      r_state <= r_state == COLLECT ? (w_go ? DIFF : COLLECT) :
                 r_state == DIFF ? MULT : r_state == MULT ? SUM : COLLECT;
      if (r_state == DIFF) r_diff <= (DATA_WIDTH+1)'(r_h_w) - (DATA_WIDTH+1)'(r_n_w);
      if (r_state == MULT) r_prod <= PW'(r_z_w) * PW'(r_diff);
      if (r_state == SUM) begin
        h_t_n <= w_sat;
        sat_flag <= w_clamped;
        valid_out <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gru_hidden_state_update_element.sv
// tb_gru_hidden_state_update_element: directed vectors with hand-computed results
module tb_gru_hidden_state_update_element;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_z = 1'b0, valid_n = 1'b0;
  logic signed [15:0] z_t_n = '0, n_t_n = '0, h_t_prev_n = '0;
  logic signed [15:0] h_t_n;
  logic valid_out, sat_flag, busy;
  int n_vec = 0, n_err = 0;
  gru_hidden_state_update_element dut (
    .clk(clk),
    .reset(reset),
    .valid_z(valid_z),
    .z_t_n(z_t_n),
    .valid_n(valid_n),
    .n_t_n(n_t_n),
    .h_t_prev_n(h_t_prev_n),
    .h_t_n(h_t_n),
    .valid_out(valid_out),
    .sat_flag(sat_flag),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pair(input logic signed [15:0] z, input logic signed [15:0] n, input logic signed [15:0] h);
    valid_z = 1'b1;
    valid_n = 1'b1;
    z_t_n = z;
    n_t_n = n;
    h_t_prev_n = h;
    tick();
    valid_z = 1'b0;
    valid_n = 1'b0;
  endtask
  task automatic result(input string tag, input logic signed [15:0] eh, input logic es);
    int cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!valid_out && cnt < 10);
    chk({tag, "_lat"}, cnt, 3);
    chk({tag, "_h"}, h_t_n, eh);
    chk({tag, "_sat"}, sat_flag, es);
    tick();
    chk({tag, "_once"}, valid_out, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask
  initial begin
    int seen;
    tick();
    tick();
    chk("rst_h", h_t_n, 0);
    chk("rst_vo", valid_out, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    pair(128, 256, -256);
    chk("t1_busy", busy, 1);
    result("t1", 0, 0);
    valid_n = 1'b1;
    n_t_n = -2000;
    tick();
    valid_n = 1'b0;
    repeat (4) tick();
    chk("t2_wait_busy", busy, 0);
    chk("t2_wait_vo", valid_out, 0);
    valid_z = 1'b1;
    z_t_n = 256;
    h_t_prev_n = 1000;
    tick();
    valid_z = 1'b0;
    result("t2", 1000, 0);
    pair(512, 30000, 32000);
    result("t3_pos", 32767, 1);
    pair(512, -30000, -32000);
    result("t3_neg", -32768, 1);
    pair(1, 0, -1);
    result("t4_floor", -1, 0);
    valid_z = 1'b1;
    z_t_n = 999;
    tick();
    z_t_n = 256;
    tick();
    valid_z = 1'b0;
    valid_n = 1'b1;
    n_t_n = 10;
    h_t_prev_n = 20;
    tick();
    valid_n = 1'b0;
    result("latest", 20, 0);
    pair(64, 400, 800);
    tick();
    valid_z = 1'b1;
    valid_n = 1'b1;
    z_t_n = 192;
    n_t_n = -100;
    h_t_prev_n = 300;
    tick();
    valid_z = 1'b0;
    valid_n = 1'b0;
    tick();
    chk("t5a_vo", valid_out, 1);
    chk("t5a_h", h_t_n, 500);
    chk("t5_gap_busy", busy, 0);
    tick();
    chk("t5_b_busy", busy, 1);
    chk("t5_b_vo0", valid_out, 0);
    tick();
    tick();
    chk("t5_b_pre", valid_out, 0);
    tick();
    chk("t5b_vo", valid_out, 1);
    chk("t5b_h", h_t_n, 200);
    tick();
    chk("t5b_once", valid_out, 0);
    pair(128, 256, 1000);
    valid_n = 1'b1;
    n_t_n = 77;
    tick();
    valid_n = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_h", h_t_n, 0);
    chk("t6_busy", busy, 0);
    seen = 0;
    valid_z = 1'b1;
    z_t_n = 0;
    tick();
    valid_z = 1'b0;
    repeat (5) begin
      seen += int'(valid_out);
      tick();
    end
    chk("t6_no_vo", seen, 0);
    chk("t6_discard", busy, 0);
    valid_n = 1'b1;
    n_t_n = 1234;
    h_t_prev_n = 5;
    tick();
    valid_n = 1'b0;
    result("t6_next", 1234, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
